// File: rtl/run_control_fsm.sv
// run_control_fsm: debounced RUN/HALT/STEP control generating the CPU clock enable
module run_control_fsm #(
  parameter int DB_CYCLES = 1000000,
  parameter int RUN_DIV   = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ebreak_i,
  input  logic             btn_mode,
  input  logic             btn_step,
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       state_o,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] ce_count
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [15:0] DIV_LAST = 16'(RUN_DIV - 1);
  typedef enum logic [1:0] {RUN = 2'b00, HALT = 2'b01, STEP = 2'b10} state_t;
  state_t state, state_n;
  logic [15:0] div, div_n;
  logic [1:0] cause_n;
  logic [1:0] btn, s1, s2, db, pulse;
  logic [DBW-1:0] cnt [2];
  logic mode_p, step_p;
  assign btn = {btn_step, btn_mode};
  assign mode_p = pulse[0];
  assign step_p = pulse[1];
  assign halted = state == HALT;
  assign state_o = state;
  // synchronize each button, accept a new level after DB_CYCLES equal samples, pulse on accepted rise
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        pulse[i] <= 1'b0;
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) begin
          cnt[i] <= '0;
          db[i] <= s2[i];
          pulse[i] <= s2[i];
        end else cnt[i] <= cnt[i] + DBW'(1);
      end
    end
  // state and divider registers
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= RUN;
      div <= '0;
    end else begin
      state <= state_n;
      div <= div_n;
    end
  // next state: ebreak beats the mode button in RUN, mode beats step in HALT, STEP lasts one cycle
  always_comb begin
    state_n = state;
    cause_n = halt_cause;
    case (state)
      RUN:
        if (cpu_ce && ebreak_i) begin
          state_n = HALT;
          cause_n = 2'b10;
        end else if (mode_p) begin
          state_n = HALT;
          cause_n = 2'b01;
        end
      HALT:
        if (mode_p) begin
          state_n = RUN;
          cause_n = 2'b00;
        end else if (step_p) state_n = STEP;
      STEP: state_n = HALT;
      default: state_n = RUN;
    endcase
    div_n = (state_n == RUN && state == RUN) ? (div == DIV_LAST ? 16'd0 : div + 16'd1) : 16'd0;
  end
  // registered outputs: cpu_ce precomputed from the next state and divider so it is glitch free
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cpu_ce <= 1'b0;
      halt_cause <= 2'b00;
      ce_count <= '0;
    end else begin
      cpu_ce <= state_n == RUN ? div_n == DIV_LAST : state_n == STEP;
      halt_cause <= cause_n;
      ce_count <= ce_count + CNT_W'(cpu_ce);
    end
endmodule

// File: tb/tb_run_control_fsm.sv
// tb_run_control_fsm: table-driven and scoreboard checks of run_control_fsm
module tb_run_control_fsm;
  logic clk = 0, rstn = 0, ebreak_i = 0, btn_mode = 0, btn_step = 0;
  logic ce1, h1, ce3, h3;
  logic [1:0] st1, hc1, st3, hc3;
  logic [15:0] cnt1, cnt3;
  int checks = 0, errors = 0, exp_cnt = 0, pulses = 0;
  logic win = 0;
  bit found;
  typedef struct {string name; logic [1:0] st; logic [1:0] cause; logic ce; int cnt;} exp_t;
  typedef struct {string name; logic m; logic s; logic e; int drive; int idle; logic [1:0] st; logic [1:0] cause; logic ce; int dcnt;} vec_t;
  exp_t sb[$];
  exp_t cur;
  vec_t tbl[9];
  always #5 clk = ~clk;
  run_control_fsm #(.DB_CYCLES(4), .RUN_DIV(1), .CNT_W(16)) u1 (
    .clk(clk), .rstn(rstn), .ebreak_i(ebreak_i), .btn_mode(btn_mode), .btn_step(btn_step),
    .cpu_ce(ce1), .halted(h1), .state_o(st1), .halt_cause(hc1), .ce_count(cnt1));
  run_control_fsm #(.DB_CYCLES(4), .RUN_DIV(3), .CNT_W(16)) u3 (
    .clk(clk), .rstn(rstn), .ebreak_i(ebreak_i), .btn_mode(btn_mode), .btn_step(btn_step),
    .cpu_ce(ce3), .halted(h3), .state_o(st3), .halt_cause(hc3), .ce_count(cnt3));
  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string n, input logic [1:0] st, input logic [1:0] cause, input logic ce, input int cnt);
    sb.push_back('{n, st, cause, ce, cnt});
  endtask
  always @(negedge clk) begin
    if (!win) pulses = 0;
    else if (ce1) pulses++;
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      cmp({cur.name, ".state"}, int'(st1), int'(cur.st));
      cmp({cur.name, ".halted"}, int'(h1), int'(cur.st == 2'b01));
      cmp({cur.name, ".cause"}, int'(hc1), int'(cur.cause));
      cmp({cur.name, ".ce"}, int'(ce1), int'(cur.ce));
      cmp({cur.name, ".count"}, int'(cnt1), cur.cnt % 65536);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{"run10",          0, 0, 0,  0, 11, 2'b00, 2'b00, 1, 10};
    tbl[1] = '{"ebreak",         0, 0, 1,  1,  3, 2'b01, 2'b10, 0,  1};
    tbl[2] = '{"ebreak_halted",  0, 0, 1,  3,  2, 2'b01, 2'b10, 0,  0};
    tbl[3] = '{"step",           0, 1, 0, 20, 10, 2'b01, 2'b10, 0,  1};
    tbl[4] = '{"mode_resume",    1, 0, 0, 10, 10, 2'b00, 2'b00, 1, 13};
    tbl[5] = '{"mode_halt",      1, 0, 0, 10,  4, 2'b01, 2'b01, 0,  7};
    tbl[6] = '{"mode_step_same", 1, 1, 0, 10, 10, 2'b00, 2'b00, 1, 13};
    tbl[7] = '{"short_mode",     1, 0, 0,  2, 10, 2'b00, 2'b00, 1, 12};
    tbl[8] = '{"ebreak2",        0, 0, 1,  1,  3, 2'b01, 2'b10, 0,  1};
    repeat (3) tick;
    expect_out("reset", 2'b00, 2'b00, 0, 0);
    cmp("reset.ce3", int'(ce3), 0);
    tick;
    rstn = 1;
    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      btn_mode = tbl[i].m;
      btn_step = tbl[i].s;
      ebreak_i = tbl[i].e;
      repeat (tbl[i].drive) tick;
      btn_mode = 0;
      btn_step = 0;
      ebreak_i = 0;
      repeat (tbl[i].idle) tick;
      exp_cnt += tbl[i].dcnt;
      expect_out(tbl[i].name, tbl[i].st, tbl[i].cause, tbl[i].ce, exp_cnt);
    end
    win = 1;
    btn_step = 1;
    tick;
    btn_step = 0;
    tick;
    btn_step = 1;
    tick;
    repeat (20) tick;
    btn_step = 0;
    repeat (10) tick;
    cmp("bounce.pulses", pulses, 1);
    win = 0;
    exp_cnt++;
    expect_out("bounce", 2'b01, 2'b10, 0, exp_cnt);
    btn_step = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (st1 == 2'b10) found = 1;
    end
    cmp("step.reached", int'(found), 1);
    rstn = 0;
    #1;
    expect_out("rst_in_step", 2'b00, 2'b00, 0, 0);
    btn_step = 0;
    tick;
    tick;
    rstn = 1;
    exp_cnt = 0;
    expect_out("post_rst", 2'b00, 2'b00, 0, 0);
    tick;
    expect_out("post_rst_run", 2'b00, 2'b00, 1, 0);
    btn_mode = 1;
    repeat (10) tick;
    btn_mode = 0;
    repeat (10) tick;
    exp_cnt += 7;
    expect_out("halt_for_div", 2'b01, 2'b01, 0, exp_cnt);
    cmp("div3.halted", int'(st3), 1);
    btn_mode = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (st3 == 2'b00) found = 1;
    end
    cmp("div3.entered", int'(found), 1);
    for (int i = 0; i < 9; i++) begin
      cmp($sformatf("div3.ce%0d", i), int'(ce3), int'(i % 3 == 2));
      tick;
    end
    btn_mode = 0;
    repeat (10) tick;
    btn_mode = 1;
    tick;
    tick;
    btn_mode = 0;
    repeat (10) tick;
    cmp("div3.short_state", int'(st3), 0);
    cmp("div3.short_cause", int'(hc3), 0);
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_control_fsm.md
RUN_CONTROL_FSM -- requirements
Module: run_control_fsm

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, the number of clk cycles a synchronized button level must stay stable before it is accepted.
REQ-002 SHALL have parameter RUN_DIV, default 1, the number of clk cycles per cpu_ce pulse in RUN; legal range 1..65535.
REQ-003 SHALL have parameter CNT_W, default 16, the width of the retired-cycle counter.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 ebreak_i  input  1  CPU decode flag: the instruction currently executing is EBREAK; meaningful only when cpu_ce=1.
REQ-007 btn_mode  input  1  raw, asynchronous, bouncy push-button that toggles RUN/HALT.
REQ-008 btn_step  input  1  raw, asynchronous, bouncy push-button that requests one CPU cycle while halted.
REQ-009 cpu_ce  output  1  CPU clock enable; the CPU commits state only on cycles where cpu_ce=1.
REQ-010 halted  output  1  1 when the FSM is in HALT.
REQ-011 state_o  output  2  FSM state encoding: RUN=00, HALT=01, STEP=10.
REQ-012 halt_cause  output  2  reason for the last halt: 00 none, 01 button, 10 ebreak.
REQ-013 ce_count  output  CNT_W  number of cpu_ce pulses since reset.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a stability counter; the debounced level SHALL update only after DB_CYCLES consecutive equal synchronized samples.
REQ-015 A rising edge of a debounced level SHALL produce a single-cycle pulse (mode_p, step_p); a held button SHALL produce no further pulses.
REQ-016 RUN: a divider counts 0..RUN_DIV-1; cpu_ce=1 exactly on cycles where divider==RUN_DIV-1; with RUN_DIV=1, cpu_ce=1 every cycle.
REQ-017 RUN -> HALT when cpu_ce=1 and ebreak_i=1 in the same cycle; the EBREAK cycle itself commits; halt_cause<=10.
REQ-018 RUN -> HALT on mode_p; halt_cause<=01; cpu_ce SHALL be 0 from the next cycle.
REQ-019 If RUN sees ebreak (REQ-017) and mode_p in the same cycle, it SHALL go to HALT with halt_cause=10.
REQ-020 HALT: cpu_ce=0; mode_p -> RUN with halt_cause<=00; step_p -> STEP; if both occur in the same cycle, mode_p wins.
REQ-021 STEP: cpu_ce=1 for exactly one cycle, then unconditionally -> HALT; halt_cause is retained; ebreak_i is ignored.
REQ-022 Button pulses arriving in STEP SHALL be dropped.
REQ-023 On every entry to RUN, the divider SHALL clear to 0, so the first cpu_ce occurs RUN_DIV cycles after entry.
REQ-024 ebreak_i SHALL be ignored whenever cpu_ce=0.
REQ-025 ce_count SHALL increment by 1 on every cycle with cpu_ce=1, wrapping modulo 2^CNT_W.
REQ-026 cpu_ce SHALL be a registered output (a function of the current state and divider only), free of glitches; no derived or gated clocks.
REQ-027 halted and state_o SHALL reflect the current registered state.

Reset
REQ-028 When rstn=0: state=RUN, divider=0, cpu_ce=0, halted=0, halt_cause=00, ce_count=0, synchronizers, debounce counters and debounced levels=0; no pulses SHALL be generated.
REQ-029 Reset asserted mid-STEP or mid-debounce SHALL abort the operation immediately; after release, the first cpu_ce SHALL follow REQ-023.

Verification (DB_CYCLES=4, RUN_DIV=1 unless stated)
REQ-030 Release reset, run 10 cycles -> cpu_ce=1 from the first post-reset RUN cycle onward, ce_count=10, halted=0.
REQ-031 In RUN, ebreak_i=1 for one cycle -> ce_count increments for that cycle, then state_o=01, halt_cause=10, cpu_ce=0 and ce_count holds.
REQ-032 Halted; pulse btn_step with 3 cycles of bounce then hold 20 cycles -> exactly one cpu_ce pulse, ce_count+1, back to HALT.
REQ-033 Halted; btn_mode and btn_step debounced on the same cycle -> state_o=00, no STEP, halt_cause=00.
REQ-034 RUN_DIV=3; enter RUN -> cpu_ce pattern 0,0,1 repeating; btn_mode held for 2 cycles only (shorter than DB_CYCLES) -> no state change.
REQ-035 Assert rstn=0 during STEP -> all outputs at reset values within the same cycle, state_o=00 after release.
